mdu_unit: RTL and testbench

//  Multiply/divide unit in the E stage of the 5-stage MIPS pipeline. Executes

---
 rtl/mdu_unit.sv | 135 +++++++++++++
 tb/tb_mdu_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multi-cycle multiply/divide unit owning HI/LO
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic [3:0]  MDU_op,
  input  logic        D_is_md,
  input  logic        Req,
  output logic        MDU_busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] counter;
  logic [31:0]      pend_hi, pend_lo;
  logic             pend_we;
  logic             start, commit, is_mult;
  logic [31:0]      res_hi, res_lo;
  logic             res_we;

  // Divider operands reduced to magnitudes; signs are reapplied afterwards
  logic [63:0]      prod_s, prod_u;
  logic [31:0]      a_mag, b_mag, b_safe, q_mag, r_mag;
  logic             a_neg, b_neg, is_signed_div;

  // Issue/commit qualification and next-state selection
  always_comb begin
    start     = (MDU_op >= OP_MULT) && (MDU_op <= OP_DIVU) && !Req && (state == S_IDLE);
    commit    = (state == S_BUSY) && (counter == CNT_W'(1));
    is_mult   = (MDU_op == OP_MULT) || (MDU_op == OP_MULTU);
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_BUSY;
      S_BUSY:  if (commit) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign MDU_busy = D_is_md && (start || (state == S_BUSY));

  // Result computation from the issuing operands; divide by zero disables the commit
  always_comb begin
    is_signed_div = (MDU_op == OP_DIV);
    a_neg   = is_signed_div && E_A[31];
    b_neg   = is_signed_div && E_B[31];
    a_mag   = a_neg ? (~E_A + 32'd1) : E_A;
    b_mag   = b_neg ? (~E_B + 32'd1) : E_B;
    b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / b_safe;
    r_mag   = a_mag % b_safe;
    prod_s  = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
    prod_u  = {32'd0, E_A} * {32'd0, E_B};
    res_we  = 1'b1;
    res_hi  = 32'd0;
    res_lo  = 32'd0;
    case (MDU_op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV, OP_DIVU: begin
        res_we = (E_B != 32'd0);
        res_lo = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        res_hi = a_neg ? (~r_mag + 32'd1) : r_mag;
      end
      default: res_we = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Latency counter and pending result captured at issue
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter <= '0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_we <= 1'b0;
    end else if (start) begin
      counter <= is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      pend_hi <= res_hi;
      pend_lo <= res_lo;
      pend_we <= res_we;
    end else if (state == S_BUSY) begin
      counter <= counter - CNT_W'(1);
      if (commit) pend_we <= 1'b0;
    end
  end

  // HI/LO update: commit of a finished op, or mthi/mtlo while idle and not flushed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      HI <= 32'd0;
      LO <= 32'd0;
    end else if (commit) begin
      if (pend_we) begin
        HI <= pend_hi;
        LO <= pend_lo;
      end
    end else if ((state == S_IDLE) && !Req) begin
      if (MDU_op == OP_MTHI) HI <= E_A;
      if (MDU_op == OP_MTLO) LO <= E_A;
    end
  end

  // Move-from read port
  always_comb begin
    MDU_out = 32'd0;
    if (MDU_op == OP_MFHI) MDU_out = HI;
    if (MDU_op == OP_MFLO) MDU_out = LO;
  end

endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - scoreboard testbench for mdu_unit
module tb_mdu_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] E_A, E_B;
  logic [3:0]  MDU_op;
  logic        D_is_md, Req;
  logic        MDU_busy;
  logic [31:0] HI, LO, MDU_out;

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .E_A(E_A), .E_B(E_B), .MDU_op(MDU_op),
    .D_is_md(D_is_md), .Req(Req), .MDU_busy(MDU_busy), .HI(HI), .LO(LO),
    .MDU_out(MDU_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
  } chk_t;

  chk_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      0:       return {31'd0, MDU_busy};
      1:       return HI;
      2:       return LO;
      default: return MDU_out;
    endcase
  endfunction

  function automatic string kname(input int kind);
    case (kind)
      0:       return "busy";
      1:       return "hi";
      2:       return "lo";
      default: return "mdu_out";
    endcase
  endfunction

  // Monitor: pop every check due in this cycle and compare on the falling edge
  chk_t c;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      c = sb.pop_front();
      n_cmp++;
      if (c.cyc < cyc) begin
        n_bad++;
        $display("FAIL stale_%s cyc=%0d due=%0d", kname(c.kind), cyc, c.cyc);
      end else if (actual(c.kind) !== c.exp) begin
        n_bad++;
        $display("FAIL %s cyc=%0d actual=%h required=%h", kname(c.kind), cyc, actual(c.kind), c.exp);
      end
    end
  end

  task automatic expect_now(input int kind, input logic [31:0] v);
    chk_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.exp  = v;
    sb.push_back(e);
  endtask

  // Reference: MIPS arithmetic done with 64-bit integer math
  function automatic void ref_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic ok, output logic [31:0] hi, output logic [31:0] lo);
    longint          sa, sbv, p;
    longint unsigned ua, ub, up;
    ok = 1'b1;
    hi = 32'd0;
    lo = 32'd0;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (op)
      4'd1: begin p = sa * sbv; {hi, lo} = p; end
      4'd2: begin up = ua * ub; {hi, lo} = up; end
      4'd3: if (b == 32'd0) ok = 1'b0;
            else begin lo = 32'(sa / sbv); hi = 32'(sa % sbv); end
      default: if (b == 32'd0) ok = 1'b0;
               else begin lo = 32'(ua / ub); hi = 32'(ua % ub); end
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue mult/multu/div/divu and follow it through commit
  task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic dmd, input int raise_at, input logic req);
    logic        ok, dm;
    logic [31:0] rh, rl;
    int          n;
    ref_md(op, a, b, ok, rh, rl);
    n = (op <= 4'd2) ? MC : DC;
    step();
    MDU_op = op; E_A = a; E_B = b; Req = req;
    D_is_md = dmd || (raise_at == 0);
    if (req) begin
      expect_now(0, 32'd0);
      step();
      MDU_op = 4'd0; Req = 1'b0;
      expect_now(0, 32'd0);
      expect_now(1, m_hi);
      expect_now(2, m_lo);
      D_is_md = 1'b0;
      return;
    end
    expect_now(0, {31'd0, D_is_md});
    for (int k = 1; k <= n + 1; k++) begin
      step();
      MDU_op = 4'd0; Req = 1'b0;
      E_A = $urandom; E_B = $urandom;
      dm = dmd || (k >= raise_at);
      D_is_md = dm;
      expect_now(0, {31'd0, dm && (k <= n)});
      if (k == n + 1 && ok) begin
        m_hi = rh;
        m_lo = rl;
      end
      if (k >= n) begin
        expect_now(1, m_hi);
        expect_now(2, m_lo);
      end
    end
    D_is_md = 1'b0;
  endtask

  task automatic run_mt(input logic [3:0] op, input logic [31:0] a, input logic req);
    step();
    MDU_op = op; E_A = a; Req = req; D_is_md = 1'b1;
    expect_now(0, 32'd0);
    step();
    MDU_op = 4'd0; Req = 1'b0; D_is_md = 1'b0;
    if (!req && op == 4'd5) m_hi = a;
    if (!req && op == 4'd6) m_lo = a;
    expect_now(1, m_hi);
    expect_now(2, m_lo);
  endtask

  task automatic run_mf(input logic [3:0] op);
    step();
    MDU_op = op;
    expect_now(3, (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    reset_n = 1'b0; MDU_op = 4'd0; E_A = 32'd0; E_B = 32'd0; D_is_md = 1'b0; Req = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    D_is_md = 1'b1;
    expect_now(0, 32'd0);
    expect_now(1, 32'd0);
    expect_now(2, 32'd0);

    run_md(4'd1, -32'sd5, 32'd3, 1'b1, 99, 1'b0);
    run_mf(4'd7);
    run_mf(4'd8);
    run_md(4'd4, 32'd7, 32'd2, 1'b1, 99, 1'b0);
    run_md(4'd3, -32'sd7, 32'd2, 1'b1, 99, 1'b0);
    run_md(4'd3, 32'd12345, 32'd0, 1'b1, 99, 1'b0);
    run_md(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 99, 1'b0);
    run_md(4'd1, 32'd9, 32'd9, 1'b1, 99, 1'b1);
    run_mt(4'd6, 32'hDEAD_BEEF, 1'b1);
    run_md(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 3, 1'b0);

    // Asynchronous reset in the middle of a divide
    step();
    MDU_op = 4'd3; E_A = 32'd100; E_B = 32'd7; D_is_md = 1'b1; Req = 1'b0;
    expect_now(0, 32'd1);
    for (int k = 1; k <= 2; k++) begin
      step();
      MDU_op = 4'd0;
      expect_now(0, 32'd1);
    end
    step();
    #2;
    reset_n = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    expect_now(0, 32'd0);
    expect_now(1, 32'd0);
    expect_now(2, 32'd0);
    step();
    reset_n = 1'b1;
    for (int k = 5; k <= 12; k++) begin
      step();
      expect_now(0, 32'd0);
      expect_now(1, 32'd0);
      expect_now(2, 32'd0);
    end
    run_mt(4'd5, 32'h0000_1234, 1'b0);
    run_mf(4'd7);

    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(1, 6));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'h0000_00FF;
      if (op <= 4'd4) run_md(op, a, b, 1'b1, 99, ($urandom_range(0, 7) == 0));
      else            run_mt(op, a, ($urandom_range(0, 4) == 0));
      run_mf(4'($urandom_range(7, 15)));
    end

    step();
    MDU_op = 4'd0;
    step();
    step();
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
